// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// spi_cfg_pkg : word layout, state encoding and default register table
//               for the SPI configuration sequencer.
// Revision    : 1.0
// ============================================================================
package spi_cfg_pkg;

  localparam int c_word_w   = 14;
  localparam int c_addr_msb = 13;
  localparam int c_addr_lsb = 9;
  localparam int c_rw_bit   = 8;
  localparam int c_data_msb = 7;
  localparam int c_data_lsb = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  function automatic logic [c_word_w-1:0] build_word(input logic [4:0] addr,
                                                     input logic       rw,
                                                     input logic [7:0] data);
    logic [c_word_w-1:0] w;
    w                         = '0;
    w[c_addr_msb:c_addr_lsb]  = addr;
    w[c_rw_bit]               = rw;
    w[c_data_msb:c_data_lsb]  = data;
    return w;
  endfunction

  localparam logic [c_word_w-1:0] c_def_word_0 = build_word(5'b01001, 1'b1, 8'h00);
  localparam logic [c_word_w-1:0] c_def_word_n = build_word(5'b01011, 1'b1, 8'h00);

  function automatic logic [c_word_w-1:0] default_word(input int idx);
    return (idx == 0) ? c_def_word_0 : c_def_word_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_table.sv
`default_nettype none
// ============================================================================
// spi_cfg_table : configuration word storage with combinational read.
//                 CFG_TABLE_WR_EN selects writable flops; otherwise constants.
// Revision      : 1.0
// ============================================================================
module spi_cfg_table
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REG = 32,
  parameter int IDX_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_allow,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [c_word_w-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [c_word_w-1:0] rd_data
);

`ifdef CFG_TABLE_WR_EN
  localparam logic [IDX_W:0] c_num_reg = (IDX_W+1)'(NUM_REG);

  logic [c_word_w-1:0] r_tbl [NUM_REG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        r_tbl[i] <= default_word(i);
      end
    end else if (wr_en && wr_allow && ({1'b0, wr_addr} < c_num_reg)) begin
      r_tbl[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_idx} < c_num_reg) ? r_tbl[rd_idx] : '0;
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, wr_en, wr_allow, wr_addr, wr_data};
  assign rd_data  = default_word(int'(rd_idx));
`endif

endmodule
`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// spi_cfg_sequencer : issues the configuration table word by word to the SPI
//                     serializer. Table writes enabled by CFG_TABLE_WR_EN.
// Revision          : 1.0
// ============================================================================
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REG        = 32,
  parameter int IDX_W          = 5,
  parameter int POWERUP_CYCLES = 2000,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                tbl_wr_en,
  input  logic [IDX_W-1:0]    tbl_wr_addr,
  input  logic [c_word_w-1:0] tbl_wr_data,
  output logic [c_word_w-1:0] word_data,
  output logic                word_valid,
  input  logic                word_ready,
  input  logic                word_done,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    cur_idx
);

  localparam int c_cnt_max_a = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
  localparam int c_cnt_max   = (c_cnt_max_a > GAP_CYCLES) ? c_cnt_max_a : GAP_CYCLES;
  localparam int c_cnt_w     = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_pwrup_last   = c_cnt_w'(POWERUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   c_last_idx     = IDX_W'(NUM_REG - 1);

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [c_word_w-1:0] w_rd_data;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_cnt_w'(1);

  // The table is read at the index the next ISSUE will use, so word_data
  // can be loaded on the same edge that raises word_valid.
  assign w_rd_idx = (r_state == ST_GAP) ? cur_idx + IDX_W'(1) : '0;

  spi_cfg_table #(
    .NUM_REG (NUM_REG),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tbl_wr_en),
    .wr_allow (~busy),
    .wr_addr  (tbl_wr_addr),
    .wr_data  (tbl_wr_data),
    .rd_idx   (w_rd_idx),
    .rd_data  (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PWRUP;
      r_cnt      <= '0;
      cur_idx    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        cur_idx    <= '0;
        word_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state    <= ST_ISSUE;
              cur_idx    <= '0;
              err        <= 1'b0;
              word_valid <= 1'b1;
              word_data  <= w_rd_data;
              busy       <= 1'b1;
            end
          end
          ST_PWRUP: begin
            if (r_cnt == c_pwrup_last) begin
              r_state    <= ST_ISSUE;
              cur_idx    <= '0;
              word_valid <= 1'b1;
              word_data  <= w_rd_data;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_ISSUE: begin
            if (word_ready) begin
              r_state    <= ST_WAIT_DONE;
              word_valid <= 1'b0;
              r_cnt      <= '0;
            end
          end
          ST_WAIT_DONE: begin
            if (word_done) begin
              r_state <= ST_GAP;
              r_cnt   <= '0;
            end else if (r_cnt == c_timeout_last) begin
              r_state <= ST_IDLE;
              err     <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_GAP: begin
            if (r_cnt == c_gap_last) begin
              if (cur_idx == c_last_idx) begin
                r_state <= ST_FINISH;
                done    <= 1'b1;
              end else begin
                r_state    <= ST_ISSUE;
                cur_idx    <= cur_idx + IDX_W'(1);
                word_valid <= 1'b1;
                word_data  <= w_rd_data;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            word_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Upstream word source for the 14-bit SPI configuration serializer; holds a NUM_REG-entry table of {addr[4:0], rw, data[7:0]} words.
- After power-up delay, or on a start pulse, issues the words in order (index 0 first) over a valid/ready handshake.
- Waits for the serializer's per-word completion pulse, then inserts an inter-word gap.
- Reports busy/done/error status to the top level and to debug logic.

Parameters:
- NUM_REG, 32, number of table entries sent per sequence (2..32)
- IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM_REG
- POWERUP_CYCLES, 2000, clk cycles to wait after reset release before the automatic first sequence (1 ms at 2 MHz)
- GAP_CYCLES, 4, idle clk cycles between word_done and the next word_valid
- TIMEOUT_CYCLES, 255, maximum clk cycles in WAIT_DONE before the error exit

Ports:
- clk  in  1  sequencer clock; same 2 MHz domain as the serializer; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; starts a sequence from IDLE, no power-up wait
- abort  in  1  level; forces IDLE from any state
- tbl_wr_en  in  1  table write strobe
- tbl_wr_addr  in  IDX_W  table write index
- tbl_wr_data  in  14  table write data
- word_data  out  14  word offered to the serializer
- word_valid  out  1  word_data valid
- word_ready  in  1  serializer accepts the word when word_valid & word_ready
- word_done  in  1  one-cycle pulse when the serializer has finished shifting the word (CS deasserted)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a sequence completes normally
- err  out  1  sticky timeout flag
- cur_idx  out  IDX_W  index of the word currently in flight

Behaviour:
- Reset values: word_data=0, word_valid=0, busy=1, done=0, err=0, cur_idx=0. State PWRUP, delay counter=0.
  - The next clk edge after rst_n release starts the power-up count.
- States: IDLE, PWRUP, ISSUE, WAIT_DONE, GAP, FINISH.
- PWRUP: counts POWERUP_CYCLES cycles, then enters ISSUE with idx=0. start is ignored in PWRUP.
- IDLE: a start pulse enters ISSUE with idx=0 and clears err in the same cycle. Only the start pulse is sampled.
- ISSUE:
  - word_valid=1 and word_data=table[idx], both registered; they are stable while valid is high.
  - A handshake (valid & ready) moves to WAIT_DONE; word_valid drops on the next cycle.
  - Ready may be held high; at most one word is in flight.
- WAIT_DONE:
  - word_done moves to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES: set err, go to IDLE, no done pulse.
  - A word_done seen outside WAIT_DONE is ignored.
- GAP: waits GAP_CYCLES, then:
  - if idx==NUM_REG-1, go to FINISH;
  - otherwise idx+1 and go to ISSUE.
  - No wrap-around of idx.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Latency: the first word_valid is asserted exactly 1 cycle after start.
- Total sequence length with ready held high and zero-latency done: NUM_REG*(2+GAP_CYCLES)+1 cycles.
- abort:
  - Highest priority; next state is IDLE and word_valid=0.
  - No done pulse; err is unchanged; idx resets to 0.
  - start and abort in the same cycle: abort wins.
- start while busy: ignored (no restart, no queuing).
- Reset mid-sequence: all state returns to reset values, including the power-up wait.
- Counters saturate, never wrap. The timeout counter clears on entry to WAIT_DONE.

Optional Feature:
- Macro CFG_TABLE_WR_EN.
- Defined:
  - The table is NUM_REG x 14 flops, initialised at reset from the package default table.
  - tbl_wr_en writes tbl_wr_data to entry tbl_wr_addr only while busy=0.
  - Writes while busy, or with addr>=NUM_REG, are dropped.
- Undefined:
  - The table is the constant package default table.
  - The tbl_* ports remain on the port list and are ignored.

Decomposition:
- Package spi_cfg_pkg holds:
  - word width (14) and field positions (addr[13:9], rw[8], data[7:0]);
  - the state encoding constants;
  - the default table: entry 0 = 14'b01001_1_0000_0000, all other entries = 14'b01011_1_0000_0000.
- Sub-module spi_cfg_table holds the storage, the write port and the combinational read by idx; it contains the CFG_TABLE_WR_EN logic.
- The FSM, counters and status logic stay in spi_cfg_sequencer.

Test Plan:
- Reset release, word_ready=1, done echoed 3 cycles after each handshake:
  - first word_valid at cycle 2000 with data 14'h1300;
  - 32 handshakes; word 1 = 14'h1700;
  - one done pulse; busy falls; err=0.
- From IDLE, start pulse → word_valid high the next cycle.
  - Second start during the sequence → ignored; total handshake count = 32.
- Hold word_ready=0 for 10 cycles in ISSUE → word_valid and word_data stay stable; handshake completes when ready rises.
- Withhold word_done after word 5 → err=1 after 255 cycles, state IDLE, no done.
  - Next start clears err and reissues from index 0.
- abort asserted during GAP of word 7 → IDLE, word_valid=0, no done.
  - Same cycle start+abort from IDLE → stays IDLE.
- CFG_TABLE_WR_EN defined:
  - write 14'h2AA5 to entry 3 while idle → fourth issued word = 14'h2AA5;
  - write during busy → dropped; undefined build ignores both writes.
